// File: rtl/cache_controller_gen2_if.sv
// Core-side request, hmem requester and tag/data datapath control signals of the
// L1 cache controller, bundled so one instance connects the controller to its neighbours.
interface cache_controller_gen2_if #(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned NUM_SETS       = 64
);
    localparam int unsigned BEAT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int unsigned SET_W  = $clog2(NUM_SETS);

    // Core request channel
    logic              req_valid;
    logic [1:0]        req_operation;
    logic              req_fulfilled;
    // Tag/data datapath status
    logic              valid_block_match;
    logic              valid_dirty_bit;
    // hmem requester
    logic              hmem_req_valid;
    logic [1:0]        hmem_req_operation;
    logic              hmem_req_single;
    logic              hmem_req_fulfilled;
    // Datapath control
    logic [BEAT_W-1:0] beat_index;
    logic              walk_active;
    logic [SET_W-1:0]  walk_set;
    logic              perform_write;
    logic              set_selected_dirty;
    logic              clear_selected_dirty;
    logic              clear_selected_valid;
    logic              finish_line_install;
    logic              set_hmem_block_addr;
    logic              use_victim_tag;
    logic              miss_recovery_mode;

    // Controller side
    modport master (
        input  req_valid, req_operation, valid_block_match, valid_dirty_bit,
               hmem_req_fulfilled,
        output req_fulfilled, hmem_req_valid, hmem_req_operation, hmem_req_single,
               beat_index, walk_active, walk_set, perform_write, set_selected_dirty,
               clear_selected_dirty, clear_selected_valid, finish_line_install,
               set_hmem_block_addr, use_victim_tag, miss_recovery_mode
    );

    // Core / datapath / hmem side
    modport slave (
        output req_valid, req_operation, valid_block_match, valid_dirty_bit,
               hmem_req_fulfilled,
        input  req_fulfilled, hmem_req_valid, hmem_req_operation, hmem_req_single,
               beat_index, walk_active, walk_set, perform_write, set_selected_dirty,
               clear_selected_dirty, clear_selected_valid, finish_line_install,
               set_hmem_block_addr, use_victim_tag, miss_recovery_mode
    );
endinterface

// File: rtl/cache_controller_gen2.sv
// L1 cache control FSM: hit handling, line fill/writeback bursts, write-through stores,
// single-line flush and a whole-cache FLUSH_ALL walk.
module cache_controller_gen2 #(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned NUM_SETS       = 64,
    parameter int unsigned WRITE_THROUGH  = 0
) (
    input logic                   clk,
    input logic                   reset_n,
    cache_controller_gen2_if.master bus
);
    localparam int unsigned BEAT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int unsigned SET_W  = $clog2(NUM_SETS);

    localparam logic [1:0] OpLoad     = 2'd0;
    localparam logic [1:0] OpStore    = 2'd1;
    localparam logic [1:0] OpClflush  = 2'd2;
    localparam logic [1:0] OpFlushAll = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StAllocate, StWriteback, StFlush, StWtStore, StWalkScan, StWalkWb
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SET_W-1:0]  walk_q, walk_d;

    logic last_beat;
    logic last_set;
    logic hit;
    logic dirty;

    assign hit       = bus.valid_block_match;
    assign dirty     = bus.valid_dirty_bit;
    assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) && bus.hmem_req_fulfilled;
    assign last_set  = (walk_q == SET_W'(NUM_SETS - 1));

    // State, beat and walk registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            walk_q  <= walk_d;
        end
    end

    // Next-state, counters and all datapath/hmem control outputs
    always_comb begin
        state_d                  = state_q;
        beat_d                   = beat_q;
        walk_d                   = walk_q;
        bus.req_fulfilled        = 1'b0;
        bus.hmem_req_valid       = 1'b0;
        bus.hmem_req_operation   = OpLoad;
        bus.hmem_req_single      = 1'b0;
        bus.beat_index           = beat_q;
        bus.walk_active          = 1'b0;
        bus.walk_set             = walk_q;
        bus.perform_write        = 1'b0;
        bus.set_selected_dirty   = 1'b0;
        bus.clear_selected_dirty = 1'b0;
        bus.clear_selected_valid = 1'b0;
        bus.finish_line_install  = 1'b0;
        bus.set_hmem_block_addr  = 1'b0;
        bus.use_victim_tag       = 1'b0;
        bus.miss_recovery_mode   = (state_q != StIdle);

        // Burst beat counter wraps modulo the line length
        if (state_q inside {StAllocate, StWriteback, StFlush, StWalkWb} &&
            bus.hmem_req_fulfilled) begin
            beat_d = (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) ? '0 : beat_q + BEAT_W'(1);
        end

        // Mealy pulses are held off while reset is asserted
        if (reset_n) begin
            unique case (state_q)
                StIdle: begin
                    beat_d = '0;
                    if (bus.req_valid) begin
                        unique case (bus.req_operation)
                            OpLoad, OpStore: begin
                                if (bus.req_operation == OpStore && WRITE_THROUGH != 0) begin
                                    // No-write-allocate: hit updates the line, hmem gets the word
                                    bus.perform_write       = hit;
                                    bus.set_hmem_block_addr = 1'b1;
                                    state_d                 = StWtStore;
                                end else if (hit) begin
                                    bus.req_fulfilled      = 1'b1;
                                    bus.perform_write      = (bus.req_operation == OpStore);
                                    bus.set_selected_dirty = (bus.req_operation == OpStore);
                                end else if (dirty) begin
                                    bus.set_hmem_block_addr = 1'b1;
                                    bus.use_victim_tag      = 1'b1;
                                    state_d                 = StWriteback;
                                end else begin
                                    bus.set_hmem_block_addr = 1'b1;
                                    state_d                 = StAllocate;
                                end
                            end
                            OpClflush: begin
                                if (!hit) begin
                                    bus.req_fulfilled = 1'b1;
                                end else if (dirty) begin
                                    bus.set_hmem_block_addr = 1'b1;
                                    bus.use_victim_tag      = 1'b1;
                                    state_d                 = StFlush;
                                end else begin
                                    bus.clear_selected_valid = 1'b1;
                                    bus.req_fulfilled        = 1'b1;
                                end
                            end
                            OpFlushAll: begin
                                walk_d  = '0;
                                state_d = StWalkScan;
                            end
                            default: ;
                        endcase
                    end
                end
                StAllocate: begin
                    bus.hmem_req_valid = 1'b1;
                    bus.perform_write  = 1'b1;
                    if (last_beat) begin
                        bus.finish_line_install  = 1'b1;
                        bus.clear_selected_dirty = 1'b1;
                        state_d                  = StIdle;
                    end
                end
                StWriteback: begin
                    bus.hmem_req_valid     = 1'b1;
                    bus.hmem_req_operation = OpStore;
                    if (last_beat) begin
                        bus.clear_selected_dirty = 1'b1;
                        bus.clear_selected_valid = 1'b1;
                        bus.set_hmem_block_addr  = 1'b1;
                        state_d                  = StAllocate;
                    end
                end
                StFlush: begin
                    bus.hmem_req_valid     = 1'b1;
                    bus.hmem_req_operation = OpStore;
                    if (last_beat) begin
                        bus.clear_selected_dirty = 1'b1;
                        bus.clear_selected_valid = 1'b1;
                        bus.req_fulfilled        = 1'b1;
                        state_d                  = StIdle;
                    end
                end
                StWtStore: begin
                    bus.hmem_req_valid     = 1'b1;
                    bus.hmem_req_operation = OpStore;
                    bus.hmem_req_single    = 1'b1;
                    if (bus.hmem_req_fulfilled) begin
                        bus.req_fulfilled = 1'b1;
                        state_d           = StIdle;
                    end
                end
                StWalkScan: begin
                    bus.walk_active = 1'b1;
                    if (dirty) begin
                        bus.set_hmem_block_addr = 1'b1;
                        bus.use_victim_tag      = 1'b1;
                        state_d                 = StWalkWb;
                    end else begin
                        bus.clear_selected_valid = 1'b1;
                        if (last_set) begin
                            bus.req_fulfilled = 1'b1;
                            walk_d            = '0;
                            state_d           = StIdle;
                        end else begin
                            walk_d = walk_q + SET_W'(1);
                        end
                    end
                end
                StWalkWb: begin
                    bus.walk_active        = 1'b1;
                    bus.hmem_req_valid     = 1'b1;
                    bus.hmem_req_operation = OpStore;
                    if (last_beat) begin
                        bus.clear_selected_dirty = 1'b1;
                        bus.clear_selected_valid = 1'b1;
                        if (last_set) begin
                            bus.req_fulfilled = 1'b1;
                            walk_d            = '0;
                            state_d           = StIdle;
                        end else begin
                            walk_d  = walk_q + SET_W'(1);
                            state_d = StWalkScan;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: poison everything so simulation exposes it
                    state_d                  = state_e'('x);
                    beat_d                   = 'x;
                    walk_d                   = 'x;
                    bus.req_fulfilled        = 1'bx;
                    bus.hmem_req_valid       = 1'bx;
                    bus.hmem_req_operation   = 'x;
                    bus.hmem_req_single      = 1'bx;
                    bus.beat_index           = 'x;
                    bus.walk_active          = 1'bx;
                    bus.walk_set             = 'x;
                    bus.perform_write        = 1'bx;
                    bus.set_selected_dirty   = 1'bx;
                    bus.clear_selected_dirty = 1'bx;
                    bus.clear_selected_valid = 1'bx;
                    bus.finish_line_install  = 1'bx;
                    bus.set_hmem_block_addr  = 1'bx;
                    bus.use_victim_tag       = 1'bx;
                    bus.miss_recovery_mode   = 1'bx;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller_gen2.sv
// Bench for cache_controller_gen2: three instances (write-back 4-word/4-set, write-through
// 4-word/4-set, write-back 1-word/2-set) driven from a table of per-cycle stimulus whose
// expected outputs are derived from the controller's transaction rules.
module tb_cache_controller_gen2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_gen2_if #(.WORDS_PER_LINE(4), .NUM_SETS(4)) if_a ();
    cache_controller_gen2_if #(.WORDS_PER_LINE(4), .NUM_SETS(4)) if_b ();
    cache_controller_gen2_if #(.WORDS_PER_LINE(1), .NUM_SETS(2)) if_c ();

    cache_controller_gen2 #(.WORDS_PER_LINE(4), .NUM_SETS(4), .WRITE_THROUGH(0)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a));
    cache_controller_gen2 #(.WORDS_PER_LINE(4), .NUM_SETS(4), .WRITE_THROUGH(1)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b));
    cache_controller_gen2 #(.WORDS_PER_LINE(1), .NUM_SETS(2), .WRITE_THROUGH(0)) u_c (
        .clk(clk), .reset_n(reset_n), .bus(if_c));

    typedef struct packed {
        logic       rf;
        logic       hv;
        logic [1:0] hop;
        logic       hs;
        logic [7:0] bi;
        logic       wa;
        logic [7:0] ws;
        logic       pw;
        logic       sd;
        logic       cd;
        logic       cv;
        logic       fi;
        logic       sa;
        logic       uv;
        logic       mr;
    } outs_t;

    typedef struct {
        int         d;
        logic       rv;
        logic [1:0] rop;
        logic       hit;
        logic       dirty;
        logic       hf;
        outs_t      e;
        int         sc;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    logic chk = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rf_n[10], uv_n[10], mr_n[10], fi_n[10], sd_n[10], wt_n[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic outs_t get_outs(input int d);
        outs_t o;
        if (d == 0)
            o = {if_a.req_fulfilled, if_a.hmem_req_valid, if_a.hmem_req_operation,
                 if_a.hmem_req_single, 8'(if_a.beat_index), if_a.walk_active,
                 8'(if_a.walk_set), if_a.perform_write, if_a.set_selected_dirty,
                 if_a.clear_selected_dirty, if_a.clear_selected_valid,
                 if_a.finish_line_install, if_a.set_hmem_block_addr, if_a.use_victim_tag,
                 if_a.miss_recovery_mode};
        else if (d == 1)
            o = {if_b.req_fulfilled, if_b.hmem_req_valid, if_b.hmem_req_operation,
                 if_b.hmem_req_single, 8'(if_b.beat_index), if_b.walk_active,
                 8'(if_b.walk_set), if_b.perform_write, if_b.set_selected_dirty,
                 if_b.clear_selected_dirty, if_b.clear_selected_valid,
                 if_b.finish_line_install, if_b.set_hmem_block_addr, if_b.use_victim_tag,
                 if_b.miss_recovery_mode};
        else
            o = {if_c.req_fulfilled, if_c.hmem_req_valid, if_c.hmem_req_operation,
                 if_c.hmem_req_single, 8'(if_c.beat_index), if_c.walk_active,
                 8'(if_c.walk_set), if_c.perform_write, if_c.set_selected_dirty,
                 if_c.clear_selected_dirty, if_c.clear_selected_valid,
                 if_c.finish_line_install, if_c.set_hmem_block_addr, if_c.use_victim_tag,
                 if_c.miss_recovery_mode};
        return o;
    endfunction

    task automatic set_in(input int d, input logic rv, input logic [1:0] rop, input logic hit,
                          input logic dirty, input logic hf);
        if_a.req_valid = 0; if_a.req_operation = 0; if_a.valid_block_match = 0;
        if_a.valid_dirty_bit = 0; if_a.hmem_req_fulfilled = 0;
        if_b.req_valid = 0; if_b.req_operation = 0; if_b.valid_block_match = 0;
        if_b.valid_dirty_bit = 0; if_b.hmem_req_fulfilled = 0;
        if_c.req_valid = 0; if_c.req_operation = 0; if_c.valid_block_match = 0;
        if_c.valid_dirty_bit = 0; if_c.hmem_req_fulfilled = 0;
        if (d == 0) begin
            if_a.req_valid = rv; if_a.req_operation = rop; if_a.valid_block_match = hit;
            if_a.valid_dirty_bit = dirty; if_a.hmem_req_fulfilled = hf;
        end else if (d == 1) begin
            if_b.req_valid = rv; if_b.req_operation = rop; if_b.valid_block_match = hit;
            if_b.valid_dirty_bit = dirty; if_b.hmem_req_fulfilled = hf;
        end else begin
            if_c.req_valid = rv; if_c.req_operation = rop; if_c.valid_block_match = hit;
            if_c.valid_dirty_bit = dirty; if_c.hmem_req_fulfilled = hf;
        end
    endtask

    task automatic push(input int d, input logic rv, input logic [1:0] rop, input logic hit,
                        input logic dirty, input logic hf, input outs_t e, input int sc);
        rec_t r;
        r.d = d; r.rv = rv; r.rop = rop; r.hit = hit; r.dirty = dirty; r.hf = hf;
        r.e = e; r.sc = sc;
        q.push_back(r);
    endtask

    // Idle cycle; a stray hmem ack must be ignored in IDLE
    task automatic idle(input int d, input int sc);
        push(d, 0, 2'd0, 0, 0, 1, '0, sc);
    endtask

    // One burst of wpl beats, each preceded by gap cycles without an ack
    task automatic burst(input int d, input logic [1:0] rop, input int wpl, input int gap,
                         input outs_t base, input outs_t fin, input int sc);
        outs_t e;
        for (int b = 0; b < wpl; b++) begin
            e = base;
            e.bi = 8'(b);
            for (int g = 0; g < gap; g++) push(d, 1, rop, 0, 0, 0, e, sc);
            if (b == wpl - 1) e = outs_t'(e | fin);
            push(d, 1, rop, 0, 0, 1, e, sc);
        end
    endtask

    // Per-cycle comparison against the table plus pulse bookkeeping per scenario
    always @(negedge clk) begin
        if (chk) begin
            outs_t got;
            got = get_outs(cur.d);
            check($sformatf("s%0d dut%0d outputs", cur.sc, cur.d), 64'(got), 64'(cur.e));
            rf_n[cur.sc] += int'(got.rf);
            uv_n[cur.sc] += int'(got.uv);
            mr_n[cur.sc] += int'(got.mr);
            fi_n[cur.sc] += int'(got.fi);
            sd_n[cur.sc] += int'(got.sd);
            wt_n[cur.sc] += int'(got.hv && got.hs && cur.hf);
        end
    end

    initial begin
        outs_t e, b, f, o;
        int    n;
        for (int i = 0; i < 10; i++) begin
            rf_n[i] = 0; uv_n[i] = 0; mr_n[i] = 0; fi_n[i] = 0; sd_n[i] = 0; wt_n[i] = 0;
        end

        // 1: load clean miss, instant acks, retry hits
        e = '0; e.sa = 1; push(0, 1, 2'd0, 0, 0, 0, e, 1);
        b = '0; b.hv = 1; b.mr = 1; b.pw = 1; f = '0; f.fi = 1; f.cd = 1;
        burst(0, 2'd0, 4, 0, b, f, 1);
        e = '0; e.rf = 1; push(0, 1, 2'd0, 1, 0, 0, e, 1);
        idle(0, 1);

        // 2: store miss, dirty victim, acks every other cycle, then fill and hit
        e = '0; e.sa = 1; e.uv = 1; push(0, 1, 2'd1, 0, 1, 0, e, 2);
        b = '0; b.hv = 1; b.hop = 2'd1; b.mr = 1; f = '0; f.cd = 1; f.cv = 1; f.sa = 1;
        burst(0, 2'd1, 4, 1, b, f, 2);
        b = '0; b.hv = 1; b.mr = 1; b.pw = 1; f = '0; f.fi = 1; f.cd = 1;
        burst(0, 2'd1, 4, 0, b, f, 2);
        e = '0; e.rf = 1; e.pw = 1; e.sd = 1; push(0, 1, 2'd1, 1, 0, 0, e, 2);
        idle(0, 2);

        // 3: write-through store hit (slow ack) then store miss over a dirty victim
        e = '0; e.sa = 1; e.pw = 1; push(1, 1, 2'd1, 1, 0, 0, e, 3);
        e = '0; e.hv = 1; e.hop = 2'd1; e.hs = 1; e.mr = 1; push(1, 1, 2'd1, 1, 0, 0, e, 3);
        e.rf = 1; push(1, 1, 2'd1, 1, 0, 1, e, 3);
        idle(1, 3);
        e = '0; e.sa = 1; push(1, 1, 2'd1, 0, 1, 0, e, 3);
        e = '0; e.hv = 1; e.hop = 2'd1; e.hs = 1; e.mr = 1; e.rf = 1;
        push(1, 1, 2'd1, 0, 1, 1, e, 3);
        idle(1, 3);
        e = '0; e.rf = 1; push(1, 1, 2'd0, 1, 0, 0, e, 3);
        idle(1, 3);

        // 4: FLUSH_ALL over 4 sets with set 2 dirty, instant acks
        push(0, 1, 2'd3, 0, 0, 0, '0, 4);
        for (int s = 0; s < 3; s++) begin
            e = '0; e.wa = 1; e.ws = 8'(s); e.mr = 1;
            if (s == 2) begin e.sa = 1; e.uv = 1; end else e.cv = 1;
            push(0, 1, 2'd3, 0, (s == 2), 0, e, 4);
        end
        b = '0; b.wa = 1; b.ws = 8'd2; b.hv = 1; b.hop = 2'd1; b.mr = 1;
        f = '0; f.cd = 1; f.cv = 1;
        burst(0, 2'd3, 4, 0, b, f, 4);
        e = '0; e.wa = 1; e.ws = 8'd3; e.cv = 1; e.rf = 1; e.mr = 1;
        push(0, 1, 2'd3, 0, 0, 0, e, 4);
        idle(0, 4);

        // 6: one-word line, CLFLUSH dirty with one wait cycle
        e = '0; e.sa = 1; e.uv = 1; push(2, 1, 2'd2, 1, 1, 0, e, 6);
        e = '0; e.hv = 1; e.hop = 2'd1; e.mr = 1; push(2, 1, 2'd2, 1, 1, 0, e, 6);
        e.cd = 1; e.cv = 1; e.rf = 1; push(2, 1, 2'd2, 1, 1, 1, e, 6);
        idle(2, 6);

        // 7: CLFLUSH absent / clean on the write-back instance
        e = '0; e.rf = 1; push(0, 1, 2'd2, 0, 0, 0, e, 7);
        idle(0, 7);
        e = '0; e.rf = 1; e.cv = 1; push(0, 1, 2'd2, 1, 0, 0, e, 7);
        idle(0, 7);

        // 8: one-word line fill and a clean 2-set walk
        e = '0; e.sa = 1; push(2, 1, 2'd0, 0, 0, 0, e, 8);
        e = '0; e.hv = 1; e.pw = 1; e.mr = 1; e.fi = 1; e.cd = 1;
        push(2, 1, 2'd0, 0, 0, 1, e, 8);
        idle(2, 8);
        push(2, 1, 2'd3, 0, 0, 0, '0, 8);
        e = '0; e.wa = 1; e.cv = 1; e.mr = 1; push(2, 1, 2'd3, 0, 0, 0, e, 8);
        e.ws = 8'd1; e.rf = 1; push(2, 1, 2'd3, 0, 0, 0, e, 8);
        idle(2, 8);

        // Pin the table itself against hand-counted cycle totals
        n = 0;
        foreach (q[i]) if (q[i].sc == 2 && q[i].e.hv && q[i].e.hop == 2'd1) n++;
        check("model s2 writeback cycles", 64'(n), 64'd8);
        n = 0;
        foreach (q[i]) if (q[i].sc == 4 && q[i].e.mr) n++;
        check("model s4 walk cycles", 64'(n), 64'd8);

        // Reset state: outputs zero even with a hit request presented
        set_in(0, 1, 2'd0, 1, 0, 0);
        #3;
        check("reset outs dut0", 64'(get_outs(0)), 64'd0);
        check("reset outs dut1", 64'(get_outs(1)), 64'd0);
        check("reset outs dut2", 64'(get_outs(2)), 64'd0);
        set_in(0, 0, 2'd0, 0, 0, 0);
        #9 reset_n = 1'b1;

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            set_in(q[i].d, q[i].rv, q[i].rop, q[i].hit, q[i].dirty, q[i].hf);
            cur = q[i];
            chk = 1'b1;
        end
        @(posedge clk);
        #1;
        chk = 1'b0;
        set_in(0, 0, 2'd0, 0, 0, 0);

        // Hand-counted pulse totals observed on the DUTs
        check("s1 req_fulfilled pulses", 64'(rf_n[1]), 64'd1);
        check("s1 finish_line_install pulses", 64'(fi_n[1]), 64'd1);
        check("s2 use_victim_tag pulses", 64'(uv_n[2]), 64'd1);
        check("s2 busy cycles", 64'(mr_n[2]), 64'd12);
        check("s3 single stores accepted", 64'(wt_n[3]), 64'd2);
        check("s3 dirty sets", 64'(sd_n[3]), 64'd0);
        check("s3 req_fulfilled pulses", 64'(rf_n[3]), 64'd3);
        check("s4 req_fulfilled pulses", 64'(rf_n[4]), 64'd1);
        check("s4 busy cycles", 64'(mr_n[4]), 64'd8);
        check("s6 req_fulfilled pulses", 64'(rf_n[6]), 64'd1);

        // 5: asynchronous reset during beat 2 of a fill
        set_in(0, 1, 2'd0, 0, 0, 0);
        @(posedge clk); #1 set_in(0, 1, 2'd0, 0, 0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        o = get_outs(0);
        check("s5 pre-reset hmem_req_valid", 64'(o.hv), 64'd1);
        check("s5 pre-reset beat_index", 64'(o.bi), 64'd2);
        #2 reset_n = 1'b0;
        #1;
        check("s5 outputs during reset", 64'(get_outs(0)), 64'd0);
        set_in(0, 0, 2'd0, 0, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = get_outs(0);
            n += int'(o.rf);
            check("s5 post-reset outputs", 64'(o), 64'd0);
        end
        check("s5 spurious req_fulfilled", 64'(n), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
